// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the user-BRAM access arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_WB, OWN_ENG} owner_e;

  localparam logic [11:0] USER_ADDR_HI = 12'h380;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: req[0] = Wishbone, req[1] = engine.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     prio_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // Grants only while the FSM is able to accept a new command.
  always_comb begin
    gnt_o = 2'b00;
    if (update_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (prio_i == OWN_WB) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one single-port BRAM between the Wishbone slave and the engine port,
// holding BRAM controls stable for DELAYS+1 cycles and returning a one-cycle ack.
module bram_access_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DELAYS  = 10,
  parameter logic [11:0] ADDR_HI = USER_ADDR_HI
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        eng_req_i,
  input  logic [3:0]  eng_wstrb_i,
  input  logic [31:0] eng_addr_i,
  input  logic [31:0] eng_wdata_i,
  output logic        eng_ack_o,
  output logic [31:0] eng_rdata_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o
);

  localparam int unsigned   CW       = $clog2(DELAYS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAYS);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;

  logic       wb_req;
  logic [3:0] wb_wstrb;
  logic [1:0] gnt;
  logic       in_access;
  logic       in_resp;

  assign wb_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == ADDR_HI);
  assign wb_wstrb = wbs_sel_i & {4{wbs_we_i}};

  rr_arb2 u_rr_arb2 (
    .req_i    ({eng_req_i, wb_req}),
    .prio_i   (prio_q),
    .update_i (state_q == IDLE),
    .gnt_o    (gnt)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      owner_q <= OWN_WB;
      prio_q  <= OWN_WB;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          owner_d = OWN_ENG;
          addr_d  = eng_addr_i;
          wdata_d = eng_wdata_i;
          wstrb_d = eng_wstrb_i;
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (gnt[0]) begin
          owner_d = OWN_WB;
          addr_d  = wbs_adr_i;
          wdata_d = wbs_dat_i;
          wstrb_d = wb_wstrb;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is sampled on the last cycle of the window, long after EN.
        if (cnt_q == CNT_LAST) begin
          rdata_d = bram_do_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        prio_d  = (owner_q == OWN_WB) ? OWN_ENG : OWN_WB;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign bram_en_o   = in_access;
  assign bram_we_o   = in_access ? wstrb_q : 4'h0;
  assign bram_addr_o = in_access ? addr_q  : 32'h0;
  assign bram_di_o   = in_access ? wdata_q : 32'h0;

  // A WB master that has dropped cyc/stb by the response cycle gets no ack.
  assign wbs_ack_o   = in_resp & (owner_q == OWN_WB) & wbs_cyc_i & wbs_stb_i;
  assign eng_ack_o   = in_resp & (owner_q == OWN_ENG);
  assign wbs_dat_o   = wbs_ack_o ? rdata_q : 32'h0;
  assign eng_rdata_o = eng_ack_o ? rdata_q : 32'h0;
  assign busy_o      = (state_q != IDLE);

endmodule
